// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer.
// Contents: state bit indices, one-hot stage constants, the stage enum,
// the FETCH/MEM sub-phase enum and default parameter values.
package core_pkg;

    localparam int ST_W = 8;

    localparam int ST_FETCH     = 0;
    localparam int ST_DECODE    = 1;
    localparam int ST_REGREAD   = 2;
    localparam int ST_EXEC      = 3;
    localparam int ST_MEM       = 4;
    localparam int ST_WRITEBACK = 5;
    localparam int ST_HALT      = 6;
    localparam int ST_FAULT     = 7;

    localparam logic [ST_W-1:0] OH_FETCH     = 8'h01;
    localparam logic [ST_W-1:0] OH_DECODE    = 8'h02;
    localparam logic [ST_W-1:0] OH_REGREAD   = 8'h04;
    localparam logic [ST_W-1:0] OH_EXEC      = 8'h08;
    localparam logic [ST_W-1:0] OH_MEM       = 8'h10;
    localparam logic [ST_W-1:0] OH_WRITEBACK = 8'h20;
    localparam logic [ST_W-1:0] OH_HALT      = 8'h40;
    localparam logic [ST_W-1:0] OH_FAULT     = 8'h80;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_TIMEOUT_CYC = 1024;
    localparam int DEF_TMR_W       = 16;

    // Stage encoding is the one-hot vector itself, so O_state is the state register.
    typedef enum logic [ST_W-1:0] {
        S_FETCH     = OH_FETCH,
        S_DECODE    = OH_DECODE,
        S_REGREAD   = OH_REGREAD,
        S_EXEC      = OH_EXEC,
        S_MEM       = OH_MEM,
        S_WRITEBACK = OH_WRITEBACK,
        S_HALT      = OH_HALT,
        S_FAULT     = OH_FAULT
    } state_e;

    typedef enum logic [0:0] {
        PH_ISSUE = 1'b0,
        PH_WAIT  = 1'b1
    } phase_e;

endpackage

// File: rtl/core_seq_wait_timer.sv
// Memory-wait watchdog counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (entry to a WAIT phase)
//   count      : one empty WAIT cycle elapsed
//   expired    : the count has reached TIMEOUT_CYC-1, so the empty WAIT
//                cycle currently being counted is the TIMEOUT_CYC-th one.
//                Deliberately independent of 'count' so the caller can gate
//                it without a combinational loop. Tied low when TIMEOUT_CYC=0.
module wait_timer #(
    parameter int TMR_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam bit ENABLE = (TIMEOUT_CYC != 0);
    localparam logic [TMR_W-1:0] LAST = ENABLE ? TMR_W'(TIMEOUT_CYC - 1) : {TMR_W{1'b0}};

    logic [TMR_W-1:0] cnt_r;

    // Watchdog count: cleared on WAIT entry, advanced per empty WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {TMR_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {TMR_W{1'b0}};
        end else if (count) begin
            cnt_r <= cnt_r + {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = ENABLE && (cnt_r == LAST);

endmodule

// File: rtl/core_seq.sv
// Multi-cycle CPU sequencer: one-hot stage vector, instruction register,
// MEM-stage skip, halt/resume, memory-wait watchdog and retire counter.
// Ports:
//   I_clk, I_reset  : clock, asynchronous active-low reset
//   I_mem_ready     : mem_ctrl can accept a request
//   I_data_ready    : one-cycle completion pulse from mem_ctrl
//   I_mem_data      : read data from mem_ctrl
//   I_mem_access    : instruction needs MEM (sampled in EXEC)
//   I_halt          : instruction is HALT (sampled in DECODE)
//   I_resume        : leave HALT
//   O_state         : one-hot stage vector
//   O_mem_exec      : memory request strobe (combinational in ISSUE)
//   O_instr         : instruction register
//   O_retired       : retired-instruction count (wraps)
//   O_fault         : sticky memory-timeout fault
module core_seq
    import core_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int TMR_W       = DEF_TMR_W
) (
    input  logic              I_clk,
    input  logic              I_reset,
    input  logic              I_mem_ready,
    input  logic              I_data_ready,
    input  logic [DATA_W-1:0] I_mem_data,
    input  logic              I_mem_access,
    input  logic              I_halt,
    input  logic              I_resume,
    output logic [ST_W-1:0]   O_state,
    output logic              O_mem_exec,
    output logic [DATA_W-1:0] O_instr,
    output logic [CNT_W-1:0]  O_retired,
    output logic              O_fault
);

    state_e            state_r, state_nx;
    phase_e            phase_r, phase_nx;
    logic [DATA_W-1:0] instr_r;
    logic [CNT_W-1:0]  retired_r;
    logic              fault_r;
    logic              mem_exec_s;
    logic              wd_clear_s;
    logic              wd_count_s;
    logic              wd_expired_s;

    wait_timer #(
        .TMR_W       (TMR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk     (I_clk),
        .rst_n   (I_reset),
        .clear   (wd_clear_s),
        .count   (wd_count_s),
        .expired (wd_expired_s)
    );

    // Next-state, phase, strobe and watchdog control.
    always_comb begin
        state_nx   = state_r;
        phase_nx   = phase_r;
        mem_exec_s = 1'b0;
        wd_clear_s = 1'b0;
        wd_count_s = 1'b0;
        case (state_r)
            S_FETCH, S_MEM: begin
                if (phase_r == PH_ISSUE) begin
                    mem_exec_s = I_mem_ready;
                    if (I_mem_ready) begin
                        phase_nx   = PH_WAIT;
                        wd_clear_s = 1'b1;
                    end else begin
                        phase_nx   = PH_ISSUE;
                    end
                end else begin
                    // Completion beats a simultaneous timeout.
                    if (I_data_ready) begin
                        phase_nx = PH_ISSUE;
                        state_nx = (state_r == S_FETCH) ? S_DECODE : S_WRITEBACK;
                    end else begin
                        wd_count_s = 1'b1;
                        if (wd_expired_s) begin
                            state_nx = S_FAULT;
                            phase_nx = PH_ISSUE;
                        end else begin
                            state_nx = state_r;
                        end
                    end
                end
            end
            S_DECODE:    state_nx = I_halt ? S_HALT : S_REGREAD;
            S_REGREAD:   state_nx = S_EXEC;
            S_EXEC:      state_nx = I_mem_access ? S_MEM : S_WRITEBACK;
            S_WRITEBACK: begin
                state_nx = S_FETCH;
                phase_nx = PH_ISSUE;
            end
            S_HALT: begin
                if (I_resume) begin
                    state_nx = S_FETCH;
                    phase_nx = PH_ISSUE;
                end else begin
                    state_nx = S_HALT;
                end
            end
            S_FAULT:     state_nx = S_FAULT;
            default: begin
                state_nx = S_FETCH;
                phase_nx = PH_ISSUE;
            end
        endcase
    end

    // Stage and phase registers.
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            state_r <= S_FETCH;
            phase_r <= PH_ISSUE;
        end else begin
            state_r <= state_nx;
            phase_r <= phase_nx;
        end
    end

    // Instruction register: captured only when a fetch completes.
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            instr_r <= {DATA_W{1'b0}};
        end else if ((state_r == S_FETCH) && (phase_r == PH_WAIT) && I_data_ready) begin
            instr_r <= I_mem_data;
        end else begin
            instr_r <= instr_r;
        end
    end

    // Retire counter, advanced as WRITEBACK is left.
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (state_r == S_WRITEBACK) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_r <= retired_r;
        end
    end

    // Sticky fault flag, set on the edge that enters FAULT.
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_r | (state_nx == S_FAULT);
        end
    end

    assign O_state    = state_r;
    assign O_mem_exec = mem_exec_s;
    assign O_instr    = instr_r;
    assign O_retired  = retired_r;
    assign O_fault    = fault_r;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq (DATA_W=16, CNT_W=4, TIMEOUT_CYC=2).
module tb_core_seq;

    logic        clk;
    logic        rst_n;
    logic        mem_ready;
    logic        data_ready;
    logic [15:0] mem_data;
    logic        mem_access;
    logic        halt;
    logic        resume;
    logic [7:0]  state;
    logic        mem_exec;
    logic [15:0] instr;
    logic [3:0]  retired;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    core_seq #(
        .DATA_W      (16),
        .CNT_W       (4),
        .TIMEOUT_CYC (2),
        .TMR_W       (16)
    ) dut (
        .I_clk        (clk),
        .I_reset      (rst_n),
        .I_mem_ready  (mem_ready),
        .I_data_ready (data_ready),
        .I_mem_data   (mem_data),
        .I_mem_access (mem_access),
        .I_halt       (halt),
        .I_resume     (resume),
        .O_state      (state),
        .O_mem_exec   (mem_exec),
        .O_instr      (instr),
        .O_retired    (retired),
        .O_fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic        dr;
        logic [15:0] data;
        logic        ma;
        logic        hlt;
        logic        res;
        logic [7:0]  st;
        logic        ex;
        logic [15:0] ins;
        logic [3:0]  ret;
        logic        flt;
    } vec_t;

    vec_t vecs[31];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic mr, input logic dr, input logic [15:0] d,
                         input logic ma, input logic h, input logic r);
        mem_ready  = mr;
        data_ready = dr;
        mem_data   = d;
        mem_access = ma;
        halt       = h;
        resume     = r;
    endtask

    // One non-memory instruction: ISSUE, WAIT, DECODE, REGREAD, EXEC, WRITEBACK.
    task automatic run_instr(input logic [15:0] d);
        @(negedge clk); drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 1'b1, d,        1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //           mr    dr    data      ma    hlt   res    st     ex    ins       ret   flt
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 16'h0000, 4'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 16'h0000, 4'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 16'h1234, 4'd0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h04, 1'b0, 16'h1234, 4'd0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 16'h1234, 4'd0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 16'h1234, 4'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 16'h1234, 4'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 16'h1234, 4'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 16'h1234, 4'd1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 16'h1234, 4'd1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 16'h1234, 4'd1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 16'h1234, 4'd1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 16'hABCD, 4'd1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h04, 1'b0, 16'hABCD, 4'd1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h08, 1'b0, 16'hABCD, 4'd1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 16'hABCD, 4'd1, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 16'hABCD, 4'd1, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 16'hABCD, 4'd1, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 16'hABCD, 4'd1, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 16'hABCD, 4'd2, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 16'h0F0F, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 16'hABCD, 4'd2, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 16'h0F0F, 4'd2, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h40, 1'b0, 16'h0F0F, 4'd2, 1'b0};
        vecs[23] = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h40, 1'b0, 16'h0F0F, 4'd2, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 16'h0F0F, 4'd2, 1'b0};
        vecs[25] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 16'h0F0F, 4'd2, 1'b0};
        vecs[26] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 16'h0F0F, 4'd2, 1'b0};
        vecs[27] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 16'h0F0F, 4'd2, 1'b0};
        vecs[28] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 16'h0F0F, 4'd2, 1'b1};
        vecs[29] = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 16'h0F0F, 4'd2, 1'b1};
        vecs[30] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 16'h0F0F, 4'd2, 1'b1};

        // Reset values, including the combinational strobe in ISSUE.
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        #12;
        check("rst_state", 32'(state), 32'h01);
        check("rst_mem_exec", 32'(mem_exec), 32'h1);
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_retired", 32'(retired), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Table: fetch/exec, ISSUE stall, data-vs-timeout, MEM waits, halt, fault.
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            drive(vecs[i].mr, vecs[i].dr, vecs[i].data, vecs[i].ma, vecs[i].hlt, vecs[i].res);
            #1;
            check($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("v%0d_mem_exec", i), 32'(mem_exec), 32'(vecs[i].ex));
            check($sformatf("v%0d_instr", i), 32'(instr), 32'(vecs[i].ins));
            check($sformatf("v%0d_retired", i), 32'(retired), 32'(vecs[i].ret));
            check($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].flt));
        end

        // Only reset leaves FAULT; it acts without a clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("fault_rst_state", 32'(state), 32'h01);
        check("fault_rst_fault", 32'(fault), 32'h0);
        check("fault_rst_instr", 32'(instr), 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // 16 retirements wrap the 4-bit counter to zero.
        for (int k = 0; k < 16; k++) begin
            run_instr(16'(k + 16'h0100));
            check($sformatf("wrap_wb%0d_state", k), 32'(state), 32'h20);
            @(negedge clk);
            drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
            check($sformatf("wrap_ret%0d", k), 32'(retired), 32'((k + 1) % 16));
        end
        check("wrap_instr", 32'(instr), 32'h010F);

        // One retirement, then reset while EXEC of the next instruction.
        run_instr(16'h2222);
        @(negedge clk); drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        #1;
        check("pre_rst_state", 32'(state), 32'h08);
        check("pre_rst_instr", 32'(instr), 32'h7777);
        check("pre_rst_retired", 32'(retired), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'h01);
        check("async_rst_mem_exec", 32'(mem_exec), 32'h1);
        check("async_rst_instr", 32'(instr), 32'h0);
        check("async_rst_retired", 32'(retired), 32'h0);
        check("async_rst_fault", 32'(fault), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_seq.md
# core_seq

Parametrised multi-cycle sequencer for the CPU core. It replaces the fixed-width `ctrl_unit` and generalises data width, retire-counter width and memory-wait timeout. It drives the one-hot stage vector that gates the decoder, register file, ALU, memory and PC, and owns the instruction register. It adds behaviour the current sequencer lacks: skipping the MEM stage for non-memory instructions, halt/resume, a bounded memory-wait watchdog with a sticky fault, and a retired-instruction counter.

## Interface
Parameters:
- DATA_W, 16, instruction and memory data width
- CNT_W, 32, retired-instruction counter width
- TIMEOUT_CYC, 1024, maximum wait cycles for a memory response; 0 disables the watchdog
- TMR_W, 16, width of the watchdog counter; TIMEOUT_CYC must be < 2^TMR_W

Ports:
- I_clk, input, 1, core clock; all state updates on the rising edge
- I_reset, input, 1, asynchronous active-low reset
- I_mem_ready, input, 1, mem_ctrl idle and able to accept a request
- I_data_ready, input, 1, single-cycle pulse from mem_ctrl on completion of a read or write
- I_mem_data, input, DATA_W, read data from mem_ctrl
- I_mem_access, input, 1, from the ALU: the current instruction needs the MEM stage; sampled in EXEC
- I_halt, input, 1, from the decoder: the current instruction is HALT; sampled in DECODE
- I_resume, input, 1, leave HALT
- O_state, output, 8, one-hot stage: bit0 FETCH, 1 DECODE, 2 REGREAD, 3 EXEC, 4 MEM, 5 WRITEBACK, 6 HALT, 7 FAULT
- O_mem_exec, output, 1, request strobe to mem_ctrl
- O_instr, output, DATA_W, instruction register
- O_retired, output, CNT_W, retired-instruction count
- O_fault, output, 1, sticky memory-timeout fault

## Operation
- FETCH and MEM each have two internal phases, ISSUE and WAIT. The O_state bit is high in both phases.
- ISSUE phase:
  - O_mem_exec = I_mem_ready (combinational).
  - If I_mem_ready=1, move to WAIT on the next edge.
  - Otherwise stay in ISSUE. The watchdog does not count in ISSUE.
- WAIT phase: I_data_ready=1 completes the phase. In FETCH WAIT, O_instr <= I_mem_data on the same edge. I_data_ready is ignored outside WAIT.
- Transitions:
  - FETCH → DECODE.
  - DECODE → HALT if I_halt=1, else REGREAD.
  - REGREAD → EXEC.
  - EXEC → MEM if I_mem_access=1, else WRITEBACK.
  - MEM → WRITEBACK.
  - WRITEBACK → FETCH(ISSUE). O_retired increments on this edge and wraps modulo 2^CNT_W.
  - HALT → FETCH(ISSUE) when I_resume=1. HALT retires nothing.
- Watchdog:
  - The counter clears on entry to any WAIT phase and increments each WAIT cycle without I_data_ready.
  - When the count equals TIMEOUT_CYC (nonzero), go to FAULT and set O_fault=1.
  - FAULT is terminal until reset, and I_resume is ignored in it.
  - If I_data_ready and the timeout occur in the same cycle, I_data_ready wins.
- If I_resume and I_halt are asserted together in DECODE, HALT is entered; I_resume is honoured only while already in HALT.

## Timing
- Reset values (asynchronous, I_reset=0): O_state=8'h01 (FETCH, ISSUE phase), O_mem_exec=I_mem_ready (ISSUE), O_instr=0, O_retired=0, O_fault=0, watchdog=0.
- Reset mid-operation abandons any outstanding memory access; mem_ctrl shares the same reset.
- Latency with I_mem_ready=1 and I_data_ready one cycle after the strobe:
  - Non-memory instruction: 6 cycles (ISSUE, WAIT, DECODE, REGREAD, EXEC, WRITEBACK).
  - Memory instruction: 8 cycles.
- Each extra wait cycle on either access adds one cycle.
- O_instr is stable from DECODE through WRITEBACK.
- O_retired is visible the cycle after WRITEBACK.
- O_fault rises on the edge after the TIMEOUT_CYC-th empty WAIT cycle.

## Structure
- Shared package core_pkg:
  - state bit indices (ST_FETCH..ST_FAULT) and ST_W=8
  - one-hot state constants
  - default parameter values
  - phase enum (PH_ISSUE, PH_WAIT)
- One sub-module, wait_timer (TMR_W, TIMEOUT_CYC):
  - inputs: clear, count
  - output: expired
  - TIMEOUT_CYC=0 ties expired low

## Test plan
- Reset, then I_mem_ready=1, data 16'h1234 returned one cycle after the strobe, I_mem_access=0 → O_state sequence 01,01,02,04,08,20,01; O_instr=16'h1234; O_retired=1.
- I_mem_ready=0 for 3 cycles in FETCH ISSUE → O_mem_exec low, state held, no fault with TIMEOUT_CYC=2; strobe on the 4th cycle.
- I_mem_access=1 with a 2-cycle data delay in MEM → state passes through 10 for 3 cycles (ISSUE plus 2 WAIT); total 9 cycles.
- TIMEOUT_CYC=4, no I_data_ready → O_state=8'h80 and O_fault=1 after 4 WAIT cycles; both persist with I_resume=1; cleared only by I_reset=0.
- I_halt=1 in DECODE → O_state=8'h40 and held, O_retired unchanged; I_resume pulse → 8'h01 next cycle.
- CNT_W=4, 16 retirements → O_retired wraps to 0; an asynchronous reset asserted mid-EXEC clears all outputs without waiting for a clock edge.
